mxrv_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the mxrv IF/ID/EX core. It watches the decoded register fields of the instruction in ID and the instruction occupying EX, and drives hold, flush and PC-redirect controls. Three events are handled: jump/branch redirection, load-use interlock and multi-cycle MUL/DIV wait. It also keeps a saturating stall-cycle performance counter.

---
 rtl/mxrv_pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_mxrv_pipe_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxrv_pipe_ctrl.sv
// Pipeline sequencing controller for the mxrv IF/ID/EX core: jump redirect,
// load-use interlock, MUL/DIV wait, and a saturating stall-cycle counter.
module mxrv_pipe_ctrl #(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_muldiv_i,
  input  logic        muldiv_done_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  output logic        pc_load_o,
  output logic [31:0] pc_load_addr_o,
  output logic        hold_if_o,
  output logic        hold_id_o,
  output logic        hold_ex_o,
  output logic        flush_id_o,
  output logic        flush_ex_o,
  output logic        muldiv_start_o,
  output logic [31:0] stall_cnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, MDWAIT = 2'd2, REDIRECT = 2'd3} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q;
  logic        haz, jump, md_go;

  assign haz = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
               ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  assign jump  = jump_req_i & ex_valid_i;
  assign md_go = ex_valid_i & ex_muldiv_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hold_if_o && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // cnt holds the remaining LDSTALL cycles; the RUN cycle that detects the
  // hazard is the first of the LOAD_LAT stalled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (jump)       state_d = REDIRECT;
        else if (md_go) state_d = MDWAIT;
        else if (haz) begin
          cnt_d   = CNT_INIT;
          state_d = (LOAD_LAT > 1) ? LDSTALL : RUN;
        end
      end
      LDSTALL: begin
        if (jump) begin
          state_d = REDIRECT;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = RUN;
        end
      end
      MDWAIT:   if (muldiv_done_i) state_d = RUN;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    pc_load_o      = 1'b0;
    hold_if_o      = 1'b0;
    hold_id_o      = 1'b0;
    hold_ex_o      = 1'b0;
    flush_id_o     = 1'b0;
    flush_ex_o     = 1'b0;
    muldiv_start_o = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (jump) begin
            pc_load_o  = 1'b1;
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
          end else if (md_go) begin
            muldiv_start_o = 1'b1;
            hold_if_o      = 1'b1;
            hold_id_o      = 1'b1;
            hold_ex_o      = 1'b1;
          end else if (haz) begin
            hold_if_o  = 1'b1;
            hold_id_o  = 1'b1;
            flush_ex_o = 1'b1;
          end
        end
        LDSTALL: begin
          if (jump) begin
            pc_load_o  = 1'b1;
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
          end else begin
            hold_if_o  = 1'b1;
            hold_id_o  = 1'b1;
            flush_ex_o = 1'b1;
          end
        end
        MDWAIT: begin
          hold_if_o = ~muldiv_done_i;
          hold_id_o = ~muldiv_done_i;
          hold_ex_o = ~muldiv_done_i;
        end
        REDIRECT: flush_id_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_load_addr_o = pc_load_o ? jump_addr_i : 32'd0;
  assign stall_cnt_o    = stall_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_mxrv_pipe_ctrl.sv
// Directed bench for mxrv_pipe_ctrl: single-cycle vector table plus
// hand-written multi-cycle sequences on LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_mxrv_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_muldiv, md_done, jump_req;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [31:0] jump_addr;

  logic pcl1, hif1, hid1, hex1, fid1, fex1, mds1;
  logic pcl3, hif3, hid3, hex3, fid3, fex3, mds3;
  logic [31:0] pca1, pca3, scnt1, scnt3;
  logic [1:0] st1, st3;

  always #5 clk = ~clk;

  mxrv_pipe_ctrl #(.LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .ex_valid_i(ex_valid),
    .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_muldiv_i(ex_muldiv),
    .muldiv_done_i(md_done), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .pc_load_o(pcl1), .pc_load_addr_o(pca1), .hold_if_o(hif1), .hold_id_o(hid1),
    .hold_ex_o(hex1), .flush_id_o(fid1), .flush_ex_o(fex1), .muldiv_start_o(mds1),
    .stall_cnt_o(scnt1), .state_o(st1));

  mxrv_pipe_ctrl #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .ex_valid_i(ex_valid),
    .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_muldiv_i(ex_muldiv),
    .muldiv_done_i(md_done), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .pc_load_o(pcl3), .pc_load_addr_o(pca3), .hold_if_o(hif3), .hold_id_o(hid3),
    .hold_ex_o(hex3), .flush_id_o(fid3), .flush_ex_o(fex3), .muldiv_start_o(mds3),
    .stall_cnt_o(scnt3), .state_o(st3));

  // control bundle order: {pc_load, hold_if, hold_id, hold_ex, flush_id, flush_ex, muldiv_start}
  wire [6:0] ctl1 = {pcl1, hif1, hid1, hex1, fid1, fex1, mds1};
  wire [6:0] ctl3 = {pcl3, hif3, hid3, hex3, fid3, fex3, mds3};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_JMP  = 7'b1000110;
  localparam logic [6:0] C_HAZ  = 7'b0110010;
  localparam logic [6:0] C_MD   = 7'b0111001;
  localparam logic [6:0] C_MDW  = 7'b0111000;
  localparam logic [6:0] C_RDIR = 7'b0000100;

  typedef struct {
    logic        idv;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, exv, ld;
    logic [4:0]  rd;
    logic        md, jr;
    logic [31:0] ja;
    logic [6:0]  ectl;
    logic [31:0] eaddr;
    logic [1:0]  est;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_muldiv = 0; md_done = 0;
    jump_req = 0; jump_addr = 0;
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_valid = v.exv; ex_is_load = v.ld; ex_rd = v.rd; ex_muldiv = v.md; md_done = 0;
    jump_req = v.jr; jump_addr = v.ja;
  endtask

  // one cycle of reset with idle inputs, leaving the bench at a negedge
  task automatic do_reset();
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic set_haz(input logic [4:0] r, input logic use_rs2);
    idle();
    id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = r;
    if (use_rs2) begin id_rs2 = r; id_rs2_used = 1; end
    else begin id_rs1 = r; id_rs1_used = 1; end
  endtask

  vec_t tv[13];

  initial begin
    tv[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,     C_NONE, 32'h0,   2'd0};
    tv[1]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0,     C_HAZ,  32'h0,   2'd0};
    tv[2]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0,     C_NONE, 32'h0,   2'd0};
    tv[3]  = '{1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0,     C_NONE, 32'h0,   2'd0};
    tv[4]  = '{1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0,     C_HAZ,  32'h0,   2'd0};
    tv[5]  = '{1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0,     C_NONE, 32'h0,   2'd0};
    tv[6]  = '{1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 32'h0,     C_NONE, 32'h0,   2'd0};
    tv[7]  = '{1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 32'h100,   C_JMP,  32'h100, 2'd3};
    tv[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100,   C_NONE, 32'h0,   2'd0};
    tv[9]  = '{1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 32'hABCD0, C_JMP,  32'hABCD0, 2'd3};
    tv[10] = '{1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'h44,    C_MD,   32'h0,   2'd2};
    tv[11] = '{1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'h80,    C_JMP,  32'h80,  2'd3};
    tv[12] = '{1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h0,     C_MD,   32'h0,   2'd2};

    idle();
    rst = 1;
    // reset with random inputs: controls forced low, state cleared
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom); ex_valid = 1'($urandom);
      ex_is_load = 1'($urandom); ex_rd = 5'($urandom); ex_muldiv = 1'($urandom);
      md_done = 1'($urandom); jump_req = 1'($urandom); jump_addr = $urandom;
      #1;
      chk("rst_ctl1", 32'(ctl1), 32'(C_NONE));
      chk("rst_ctl3", 32'(ctl3), 32'(C_NONE));
      chk("rst_addr", pca1, 32'h0);
      @(negedge clk);
      chk("rst_state", 32'(st1), 32'd0);
    end
    rst = 0;
    idle();
    @(negedge clk);
    chk("rst_scnt1", scnt1, 32'd0);
    chk("rst_scnt3", scnt3, 32'd0);

    // single-cycle vectors from RUN on the LOAD_LAT=1 instance
    for (int i = 0; i < 13; i++) begin
      do_reset();
      apply(tv[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl1), 32'(tv[i].ectl));
      chk($sformatf("vec%0d_addr", i), pca1, tv[i].eaddr);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(st1), 32'(tv[i].est));
    end

    // LOAD_LAT=1: one stalled cycle counted
    do_reset();
    set_haz(5'd5, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk("ll1_after_ctl", 32'(ctl1), 32'(C_NONE));
    chk("ll1_scnt", scnt1, 32'd1);

    // LOAD_LAT=3: three consecutive hold cycles via rs2
    do_reset();
    set_haz(5'd12, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ll3_hold%0d", c), 32'(ctl3), 32'(C_HAZ));
      @(negedge clk);
      chk($sformatf("ll3_state%0d", c), 32'(st3), (c < 2) ? 32'd1 : 32'd0);
    end
    idle();
    #1;
    chk("ll3_release", 32'(ctl3), 32'(C_NONE));
    chk("ll3_scnt", scnt3, 32'd3);

    // LOAD_LAT=3: jump in the last stall cycle aborts into REDIRECT
    do_reset();
    set_haz(5'd12, 1'b1);
    @(negedge clk);
    @(negedge clk);
    jump_req = 1; jump_addr = 32'h200;
    #1;
    chk("ll3j_ctl", 32'(ctl3), 32'(C_JMP));
    chk("ll3j_addr", pca3, 32'h200);
    @(negedge clk);
    chk("ll3j_state", 32'(st3), 32'd3);
    idle();
    #1;
    chk("ll3j_rdir", 32'(ctl3), 32'(C_RDIR));
    @(negedge clk);
    chk("ll3j_run", 32'(st3), 32'd0);
    chk("ll3j_scnt", scnt3, 32'd2);

    // jump then REDIRECT ignoring a repeated jump request
    do_reset();
    idle();
    ex_valid = 1; jump_req = 1; jump_addr = 32'h0000_0100;
    #1;
    chk("jmp_ctl", 32'(ctl1), 32'(C_JMP));
    chk("jmp_addr", pca1, 32'h100);
    @(negedge clk);
    jump_addr = 32'h300;
    #1;
    chk("jmp_rdir", 32'(ctl1), 32'(C_RDIR));
    chk("jmp_rdir_addr", pca1, 32'h0);
    @(negedge clk);
    chk("jmp_back", 32'(st1), 32'd0);

    // MUL/DIV: done in the start cycle ignored, 4 wait cycles, jump ignored
    do_reset();
    idle();
    ex_valid = 1; ex_muldiv = 1; md_done = 1;
    #1;
    chk("md_start", 32'(ctl1), 32'(C_MD));
    @(negedge clk);
    chk("md_state", 32'(st1), 32'd2);
    md_done = 0;
    for (int c = 1; c <= 4; c++) begin
      jump_req = (c == 2); jump_addr = 32'h400;
      #1;
      chk($sformatf("md_wait%0d", c), 32'(ctl1), 32'(C_MDW));
      @(negedge clk);
    end
    jump_req = 0; md_done = 1;
    #1;
    chk("md_done", 32'(ctl1), 32'(C_NONE));
    @(negedge clk);
    chk("md_run", 32'(st1), 32'd0);
    chk("md_scnt", scnt1, 32'd5);
    idle();

    // saturation of the stall counter
    do_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    set_haz(5'd3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("sat%0d", c), scnt1, 32'hFFFF_FFFF);
    end

    // reset in MDWAIT abandons the wait
    do_reset();
    idle();
    ex_valid = 1; ex_muldiv = 1;
    @(negedge clk);
    chk("mdr_state", 32'(st1), 32'd2);
    rst = 1;
    #1;
    chk("mdr_forced", 32'(ctl1), 32'(C_NONE));
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    chk("mdr_state_run", 32'(st1), 32'd0);
    chk("mdr_ctl", 32'(ctl1), 32'(C_NONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
